// File: rtl/better_neighbor_scan_pkg.sv
// rtl/better_neighbor_scan_pkg.sv - shared constants, state encoding and address helpers for the neighbour scan
package better_neighbor_scan_pkg;

  localparam int WORD_WIDTH = 16;
  typedef logic [WORD_WIDTH-1:0] word_t;

  localparam word_t NCOUNT_ADDR   = 16'h0600;
  localparam word_t NTABLE_BASE   = 16'h0602;
  localparam word_t BETTER_BASE   = 16'h0668;
  localparam word_t BCOUNT_ADDR   = 16'h068C;
  localparam word_t MAX_NEIGHBORS = 16'd18;
  localparam word_t NONE_ID       = 16'd301;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RDCNT,
    S_RDID,
    S_RDVAL,
    S_CMP,
    S_WRB,
    S_NEXT,
    S_WRCNT,
    S_FIN
  } state_t;

  // Entry idx occupies two words: ID at +0, value at +2.
  function automatic word_t entry_addr(input word_t idx);
    return NTABLE_BASE + {idx[13:0], 2'b00};
  endfunction

  function automatic word_t better_addr(input word_t k);
    return BETTER_BASE + {k[14:0], 1'b0};
  endfunction

endpackage

// File: rtl/better_neighbor_scan_if.sv
// rtl/better_neighbor_scan_if.sv - control, result and shared-memory signals of the neighbour scan
interface better_neighbor_scan_if;
  import better_neighbor_scan_pkg::*;

  logic  start_scan;
  word_t mybest;
  word_t MY_NODE_ID;
  word_t data_in;
  word_t address;
  word_t data_out;
  logic  wr_en;
  word_t besthop;
  word_t bestvalue;
  word_t bestneighborID;
  word_t betterNeighborCount;
  logic  done_scan;

  modport slave (
    input  start_scan, mybest, MY_NODE_ID, data_in,
    output address, data_out, wr_en, besthop, bestvalue, bestneighborID,
           betterNeighborCount, done_scan
  );

  modport master (
    output start_scan, mybest, MY_NODE_ID, data_in,
    input  address, data_out, wr_en, besthop, bestvalue, bestneighborID,
           betterNeighborCount, done_scan
  );

endinterface

// File: rtl/better_neighbor_scan_max_update.sv
// rtl/better_neighbor_scan_max_update.sv - decides whether a neighbour displaces the held besthop / best value
// BNS_TIEBREAK_LOW_ID_EN: equal values are won by the lower ID instead of the first seen (or self).
module better_neighbor_scan_max_update
  import better_neighbor_scan_pkg::*;
(
  input  word_t i_value,
  input  word_t i_id,
  input  logic  i_hop_valid,
  input  word_t i_hop_value,
  input  word_t i_hop_id,
  input  word_t i_best_value,
  input  word_t i_best_id,
  output logic  o_take_hop,
  output logic  o_take_best
);

`ifdef BNS_TIEBREAK_LOW_ID_EN
  assign o_take_hop  = !i_hop_valid || (i_value > i_hop_value) ||
                       ((i_value == i_hop_value) && (i_id < i_hop_id));
  assign o_take_best = (i_value > i_best_value) ||
                       ((i_value == i_best_value) && (i_id < i_best_id));
`else
  assign o_take_hop  = !i_hop_valid || (i_value > i_hop_value);
  assign o_take_best = (i_value > i_best_value);
  // Held IDs only matter for tie-breaking.
  logic w_unused_ids;
  assign w_unused_ids = ^{i_hop_id, i_best_id};
`endif

endmodule

// File: rtl/better_neighbor_scan.sv
// rtl/better_neighbor_scan.sv - walks the neighbour table, lists strictly better neighbours and tracks the best hop
// BNS_TIEBREAK_LOW_ID_EN selects lower-ID tie-breaking in the max update.
module better_neighbor_scan
  import better_neighbor_scan_pkg::*;
(
  input  logic clock,
  input  logic rst,
  better_neighbor_scan_if.slave bus
);

  state_t r_state, w_state_nxt;
  word_t  r_address,  w_address_nxt;
  word_t  r_data_out, w_data_out_nxt;
  logic   r_wr_en,    w_wr_en_nxt;
  word_t  r_besthop,  w_besthop_nxt;
  word_t  r_hop_val,  w_hop_val_nxt;
  logic   r_hop_valid, w_hop_valid_nxt;
  word_t  r_bestvalue, w_bestvalue_nxt;
  word_t  r_bestid,   w_bestid_nxt;
  word_t  r_bcount,   w_bcount_nxt;
  logic   r_done,     w_done_nxt;
  word_t  r_n,        w_n_nxt;
  word_t  r_i,        w_i_nxt;
  word_t  r_k,        w_k_nxt;
  word_t  r_id,       w_id_nxt;
  word_t  r_v,        w_v_nxt;

  word_t  w_n_clamped;
  word_t  w_i_inc;
  logic   w_take_hop;
  logic   w_take_best;

  assign w_n_clamped = (bus.data_in > MAX_NEIGHBORS) ? MAX_NEIGHBORS : bus.data_in;
  assign w_i_inc     = r_i + 16'd1;

  better_neighbor_scan_max_update u_max_update (
    .i_value      (r_v),
    .i_id         (r_id),
    .i_hop_valid  (r_hop_valid),
    .i_hop_value  (r_hop_val),
    .i_hop_id     (r_besthop),
    .i_best_value (r_bestvalue),
    .i_best_id    (r_bestid),
    .o_take_hop   (w_take_hop),
    .o_take_best  (w_take_best)
  );

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_address   <= '0;
      r_data_out  <= '0;
      r_wr_en     <= 1'b0;
      r_besthop   <= NONE_ID;
      r_hop_val   <= '0;
      r_hop_valid <= 1'b0;
      r_bestvalue <= '0;
      r_bestid    <= '0;
      r_bcount    <= '0;
      r_done      <= 1'b0;
      r_n         <= '0;
      r_i         <= '0;
      r_k         <= '0;
      r_id        <= '0;
      r_v         <= '0;
    end else begin
      r_address   <= w_address_nxt;
      r_data_out  <= w_data_out_nxt;
      r_wr_en     <= w_wr_en_nxt;
      r_besthop   <= w_besthop_nxt;
      r_hop_val   <= w_hop_val_nxt;
      r_hop_valid <= w_hop_valid_nxt;
      r_bestvalue <= w_bestvalue_nxt;
      r_bestid    <= w_bestid_nxt;
      r_bcount    <= w_bcount_nxt;
      r_done      <= w_done_nxt;
      r_n         <= w_n_nxt;
      r_i         <= w_i_nxt;
      r_k         <= w_k_nxt;
      r_id        <= w_id_nxt;
      r_v         <= w_v_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_address_nxt   = r_address;
    w_data_out_nxt  = r_data_out;
    w_wr_en_nxt     = r_wr_en;
    w_besthop_nxt   = r_besthop;
    w_hop_val_nxt   = r_hop_val;
    w_hop_valid_nxt = r_hop_valid;
    w_bestvalue_nxt = r_bestvalue;
    w_bestid_nxt    = r_bestid;
    w_bcount_nxt    = r_bcount;
    w_done_nxt      = r_done;
    w_n_nxt         = r_n;
    w_i_nxt         = r_i;
    w_k_nxt         = r_k;
    w_id_nxt        = r_id;
    w_v_nxt         = r_v;

    unique case (r_state)
      S_IDLE: begin
        if (bus.start_scan) begin
          w_done_nxt    = 1'b0;
          w_address_nxt = NCOUNT_ADDR;
          w_n_nxt       = '0;
          w_i_nxt       = '0;
          w_k_nxt       = '0;
          w_id_nxt      = '0;
          w_v_nxt       = '0;
          w_state_nxt   = S_RDCNT;
        end
      end
      S_RDCNT: begin
        w_n_nxt         = w_n_clamped;
        w_i_nxt         = '0;
        w_k_nxt         = '0;
        w_bestvalue_nxt = bus.mybest;
        w_bestid_nxt    = bus.MY_NODE_ID;
        w_besthop_nxt   = NONE_ID;
        w_hop_val_nxt   = '0;
        w_hop_valid_nxt = 1'b0;
        if (w_n_clamped == '0) begin
          w_state_nxt = S_WRCNT;
        end else begin
          w_address_nxt = NTABLE_BASE;
          w_state_nxt   = S_RDID;
        end
      end
      S_RDID: begin
        w_id_nxt      = bus.data_in;
        w_address_nxt = r_address + 16'd2;
        w_state_nxt   = S_RDVAL;
      end
      S_RDVAL: begin
        w_v_nxt     = bus.data_in;
        w_state_nxt = S_CMP;
      end
      S_CMP: begin
        if (w_take_hop) begin
          w_besthop_nxt   = r_id;
          w_hop_val_nxt   = r_v;
          w_hop_valid_nxt = 1'b1;
        end
        if (w_take_best) begin
          w_bestvalue_nxt = r_v;
          w_bestid_nxt    = r_id;
        end
        if (r_v > bus.mybest) begin
          w_data_out_nxt = r_id;
          w_address_nxt  = better_addr(r_k);
          w_wr_en_nxt    = 1'b1;
          w_k_nxt        = r_k + 16'd1;
          w_state_nxt    = S_WRB;
        end else begin
          w_state_nxt = S_NEXT;
        end
      end
      S_WRB: begin
        w_wr_en_nxt = 1'b0;
        w_state_nxt = S_NEXT;
      end
      S_NEXT: begin
        w_i_nxt = w_i_inc;
        if (w_i_inc == r_n) begin
          w_state_nxt = S_WRCNT;
        end else begin
          w_address_nxt = entry_addr(w_i_inc);
          w_state_nxt   = S_RDID;
        end
      end
      S_WRCNT: begin
        w_address_nxt  = BCOUNT_ADDR;
        w_data_out_nxt = r_k;
        w_wr_en_nxt    = 1'b1;
        w_bcount_nxt   = r_k;
        w_state_nxt    = S_FIN;
      end
      S_FIN: begin
        w_wr_en_nxt = 1'b0;
        w_done_nxt  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_wr_en_nxt = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.address             = r_address;
  assign bus.data_out            = r_data_out;
  assign bus.wr_en               = r_wr_en;
  assign bus.besthop             = r_besthop;
  assign bus.bestvalue           = r_bestvalue;
  assign bus.bestneighborID      = r_bestid;
  assign bus.betterNeighborCount = r_bcount;
  assign bus.done_scan           = r_done;

endmodule

// File: tb/tb_better_neighbor_scan.sv
// tb/tb_better_neighbor_scan.sv - randomized and directed checks of better_neighbor_scan against a list-level model
module tb_better_neighbor_scan;

  logic clock = 1'b0;
  logic rst;
  always #5 clock = ~clock;

  better_neighbor_scan_if bus();

  better_neighbor_scan dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus)
  );

  logic [15:0] mem [0:1023];
  assign bus.data_in = mem[bus.address[10:1]];

  logic [31:0] wlog[$];
  always @(negedge clock) begin
    if (bus.wr_en) wlog.push_back({bus.address, bus.data_out});
  end

  int n_compared = 0;
  int n_mismatched = 0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int          t_n;
  logic [15:0] t_ids [25];
  logic [15:0] t_vals [25];
  logic [15:0] t_mybest;
  logic [15:0] t_myid;
  logic [15:0] last_besthop;

  task automatic load_table();
    logic [15:0] a;
    for (int w = 0; w < 1024; w++) mem[w] = 16'hDEAD;
    a = 16'h0600;
    mem[a[10:1]] = t_n[15:0];
    for (int i = 0; i < 25; i++) begin
      a = 16'h0602 + 16'(4 * i);
      mem[a[10:1]] = t_ids[i];
      a = a + 16'd2;
      mem[a[10:1]] = t_vals[i];
    end
  endtask

  task automatic run_scan(input string name, input bit pulse_mid);
    int          n, k, cycles, exp_lat, logsz, hop_idx;
    logic [15:0] maxv, hop, bval, bid;
    logic [31:0] exp_w[$];

    n = (t_n > 18) ? 18 : t_n;
    k = 0;
    for (int i = 0; i < n; i++) begin
      if (t_vals[i] > t_mybest) begin
        exp_w.push_back({16'h0668 + 16'(2 * k), t_ids[i]});
        k++;
      end
    end
    exp_w.push_back({16'h068C, 16'(k)});
    exp_lat = 4 + 4 * n + k;

    maxv = 16'd0;
    for (int i = 0; i < n; i++) if (t_vals[i] > maxv) maxv = t_vals[i];
    hop = 16'd301;
    hop_idx = -1;
    for (int i = 0; i < n; i++) begin
      if (t_vals[i] == maxv) begin
`ifdef BNS_TIEBREAK_LOW_ID_EN
        if (hop_idx < 0 || t_ids[i] < hop) begin hop = t_ids[i]; hop_idx = i; end
`else
        if (hop_idx < 0) begin hop = t_ids[i]; hop_idx = i; end
`endif
      end
    end
    if (n == 0 || maxv < t_mybest) begin
      bval = t_mybest; bid = t_myid;
    end else if (maxv > t_mybest) begin
      bval = maxv; bid = hop;
    end else begin
      bval = t_mybest;
`ifdef BNS_TIEBREAK_LOW_ID_EN
      bid = (hop < t_myid) ? hop : t_myid;
`else
      bid = t_myid;
`endif
    end

    load_table();
    bus.mybest = t_mybest;
    bus.MY_NODE_ID = t_myid;
    wlog.delete();
    @(negedge clock);
    bus.start_scan = 1'b1;
    @(negedge clock);
    bus.start_scan = 1'b0;
    cycles = 1;
    while (!bus.done_scan && cycles < 400) begin
      @(negedge clock);
      cycles++;
      if (pulse_mid) begin
        if (cycles == 5) bus.start_scan = 1'b1;
        else if (cycles == 6) bus.start_scan = 1'b0;
      end
    end
    check_value({name, ".latency"}, cycles, exp_lat);
    logsz = wlog.size();
    repeat (pulse_mid ? 12 : 3) @(negedge clock);
    check_value({name, ".done_held"}, bus.done_scan, 1'b1);
    check_value({name, ".no_extra_writes"}, wlog.size(), logsz);
    check_value({name, ".nwrites"}, wlog.size(), exp_w.size());
    for (int i = 0; i < exp_w.size() && i < wlog.size(); i++)
      check_value($sformatf("%s.write%0d", name, i), wlog[i], exp_w[i]);
    check_value({name, ".count"}, bus.betterNeighborCount, k);
    check_value({name, ".besthop"}, bus.besthop, hop);
    check_value({name, ".bestvalue"}, bus.bestvalue, bval);
    check_value({name, ".bestid"}, bus.bestneighborID, bid);
    last_besthop = bus.besthop;
  endtask

  initial begin
    int wait_cyc;
    bit saw_cnt;
    rst = 1'b1;
    bus.start_scan = 1'b0;
    bus.mybest = 16'd0;
    bus.MY_NODE_ID = 16'd0;
    for (int w = 0; w < 1024; w++) mem[w] = 16'd0;
    repeat (3) @(negedge clock);
    rst = 1'b0;
    @(negedge clock);
    check_value("rst.address", bus.address, 16'd0);
    check_value("rst.wr_en", bus.wr_en, 1'b0);
    check_value("rst.besthop", bus.besthop, 16'd301);
    check_value("rst.bestvalue", bus.bestvalue, 16'd0);
    check_value("rst.bestid", bus.bestneighborID, 16'd0);
    check_value("rst.count", bus.betterNeighborCount, 16'd0);
    check_value("rst.done", bus.done_scan, 1'b0);

    // T1: empty table
    t_n = 0; t_mybest = 16'h0040; t_myid = 16'd42;
    for (int i = 0; i < 25; i++) begin t_ids[i] = 16'(i + 1); t_vals[i] = 16'hFFFF; end
    run_scan("t1", 1'b0);

    // T2
    t_n = 3; t_mybest = 16'h0040; t_myid = 16'd1;
    t_ids[0] = 16'd5; t_vals[0] = 16'h0020;
    t_ids[1] = 16'd7; t_vals[1] = 16'h0080;
    t_ids[2] = 16'd9; t_vals[2] = 16'h0060;
    run_scan("t2", 1'b0);

    // T3: over capacity, every entry better
    t_n = 25; t_mybest = 16'h0040; t_myid = 16'd2;
    for (int i = 0; i < 25; i++) begin t_ids[i] = 16'(100 + i); t_vals[i] = 16'(16'h0100 + i); end
    run_scan("t3", 1'b0);

    // T4: tie between IDs 9 and 4
    t_n = 2; t_mybest = 16'h0040; t_myid = 16'd50;
    t_ids[0] = 16'd9; t_vals[0] = 16'h0080;
    t_ids[1] = 16'd4; t_vals[1] = 16'h0080;
    run_scan("t4", 1'b0);
`ifdef BNS_TIEBREAK_LOW_ID_EN
    check_value("t4.tie_hop", last_besthop, 16'd4);
`else
    check_value("t4.tie_hop", last_besthop, 16'd9);
`endif

    // T5: reset during the first better-list write
    t_n = 3; t_mybest = 16'h0040; t_myid = 16'd1;
    t_ids[0] = 16'd11; t_vals[0] = 16'h0090;
    t_ids[1] = 16'd12; t_vals[1] = 16'h0010;
    t_ids[2] = 16'd13; t_vals[2] = 16'h00A0;
    load_table();
    bus.mybest = t_mybest;
    bus.MY_NODE_ID = t_myid;
    wlog.delete();
    @(negedge clock);
    bus.start_scan = 1'b1;
    @(negedge clock);
    bus.start_scan = 1'b0;
    wait_cyc = 0;
    while (!bus.wr_en && wait_cyc < 50) begin @(negedge clock); wait_cyc++; end
    check_value("t5.reached_wrb", bus.wr_en, 1'b1);
    #1 rst = 1'b1;
    #1;
    check_value("t5.wr_en_drop", bus.wr_en, 1'b0);
    check_value("t5.address", bus.address, 16'd0);
    check_value("t5.besthop", bus.besthop, 16'd301);
    check_value("t5.bestvalue", bus.bestvalue, 16'd0);
    check_value("t5.count", bus.betterNeighborCount, 16'd0);
    check_value("t5.done", bus.done_scan, 1'b0);
    repeat (2) @(negedge clock);
    rst = 1'b0;
    repeat (3) @(negedge clock);
    saw_cnt = 1'b0;
    foreach (wlog[i]) if (wlog[i][31:16] == 16'h068C) saw_cnt = 1'b1;
    check_value("t5.no_count_write", saw_cnt, 1'b0);
    run_scan("t5.rerun", 1'b0);

    // T6: start pulse while busy
    t_n = 4; t_mybest = 16'h0030; t_myid = 16'd77;
    for (int i = 0; i < 4; i++) begin t_ids[i] = 16'(20 + i); t_vals[i] = 16'(16'h0010 * (i + 2)); end
    run_scan("t6", 1'b1);

    for (int r = 0; r < 20; r++) begin
      t_n = $urandom_range(0, 25);
      t_mybest = 16'($urandom_range(0, 8) * 16);
      t_myid = 16'($urandom_range(1, 300));
      for (int i = 0; i < 25; i++) begin
        t_ids[i] = 16'($urandom_range(1, 300));
        t_vals[i] = 16'($urandom_range(0, 8) * 16);
      end
      run_scan($sformatf("rand%0d", r), (t_n >= 2) && ($urandom_range(0, 1) == 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
